// File: rtl/pu_i2c_pkg.sv
// Shared types and helpers for the I2C slave word sequencer.
// Word sizing functions, TX FSM encoding and idle byte default.
package pu_i2c_pkg;

   typedef enum logic {
      TX_IDLE   = 1'b0,
      TX_ACTIVE = 1'b1
   } tx_state_t;

   localparam logic [7:0] TX_IDLE_BYTE_DEF = 8'h00;

   function automatic int bytes_per_word(input int dw, input int iw);
      return dw / iw;
   endfunction

   function automatic int cnt_width(input int bytes);
      return $clog2(bytes + 1);
   endfunction

endpackage

// File: rtl/pu_i2c_word_fifo.sv
// Small synchronous word FIFO with registered storage.
// Push while full is accepted only when a pop happens in the same cycle.
module pu_i2c_word_fifo
   import pu_i2c_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [CW-1:0]    r_cnt;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_cnt == CW'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign o_data  = r_mem[r_rd];
   assign w_pop   = i_pop && !o_empty;
   assign w_push  = i_push && (!o_full || w_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= r_wr + AW'(1);
         end
         if (w_pop) r_rd <= r_rd + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/pu_i2c_slave_word_ctrl.sv
// Word sequencer between the I2C slave byte driver and the PU dataflow:
// RX byte assembly into a FIFO, TX word split into bytes on driver strobes.
module pu_i2c_slave_word_ctrl
   import pu_i2c_pkg::*;
#(
   parameter int I2C_DATA_WIDTH = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int RX_DEPTH       = 2,
   parameter logic [I2C_DATA_WIDTH-1:0] TX_IDLE_BYTE = TX_IDLE_BYTE_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [I2C_DATA_WIDTH-1:0] byte_rx,
   input  logic                      byte_rx_stb,
   input  logic                      byte_rd_start,
   input  logic                      byte_next,
   input  logic                      bus_idle,
   output logic [I2C_DATA_WIDTH-1:0] byte_tx,
   output logic [DATA_WIDTH-1:0]     rx_data,
   output logic                      rx_valid,
   input  logic                      rx_ready,
   input  logic [DATA_WIDTH-1:0]     tx_data,
   input  logic                      tx_valid,
   output logic                      tx_ready,
   output logic                      rx_overflow,
   output logic                      tx_underrun,
   input  logic                      err_clr
);

   localparam int IW    = I2C_DATA_WIDTH;
   localparam int DW    = DATA_WIDTH;
   localparam int BYTES = bytes_per_word(DW, IW);
   localparam int CW    = cnt_width(BYTES);
   localparam logic [CW-1:0] LAST = CW'(BYTES - 1);
   localparam logic [CW-1:0] NB   = CW'(BYTES);

   logic [2:0]       r_stb_q;
   logic [2:0]       r_stb_d;
   logic [2:0]       w_ev;
   logic [IW-1:0]    r_rx_byte;
   logic [DW-IW-1:0] r_rx_sh;
   logic [CW-1:0]    r_rx_cnt;
   logic [DW-1:0]    w_rx_word;
   logic             w_rx_done;
   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic             w_pop;

   logic             r_tx_full;
   logic [DW-1:0]    r_tx_hold;
   tx_state_t        r_tx_state;
   tx_state_t        w_tx_state_n;
   logic [DW-1:0]    r_tx_sh;
   logic [DW-1:0]    w_tx_sh_n;
   logic [CW-1:0]    r_tx_idx;
   logic [CW-1:0]    w_tx_idx_n;
   logic [IW-1:0]    r_byte_tx;
   logic [IW-1:0]    w_byte_n;
   logic             w_tx_take;
   logic             w_unrun;

   // Strobes are levels; one event per rising edge of the registered copy.
   assign w_ev = r_stb_q & ~r_stb_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stb_q   <= '0;
         r_stb_d   <= '0;
         r_rx_byte <= '0;
      end else begin
         r_stb_q   <= {byte_next, byte_rd_start, byte_rx_stb};
         r_stb_d   <= r_stb_q;
         r_rx_byte <= byte_rx;
      end
   end

   assign w_rx_word = {r_rx_sh, r_rx_byte};
   assign w_rx_done = w_ev[0] && !bus_idle && (r_rx_cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_sh  <= '0;
         r_rx_cnt <= '0;
      end else if (bus_idle) begin
         r_rx_cnt <= '0;
      end else if (w_ev[0]) begin
         r_rx_sh  <= w_rx_word[DW-IW-1:0];
         r_rx_cnt <= w_rx_done ? '0 : r_rx_cnt + CW'(1);
      end
   end

   pu_i2c_word_fifo #(
      .WIDTH (DW),
      .DEPTH (RX_DEPTH)
   ) u_rx_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_rx_done),
      .i_data  (w_rx_word),
      .i_pop   (rx_ready),
      .o_data  (rx_data),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   assign rx_valid = !w_fifo_empty;
   assign w_pop    = rx_ready && rx_valid;
   assign tx_ready = !r_tx_full;
   assign byte_tx  = r_byte_tx;

   always_comb begin
      w_tx_state_n = r_tx_state;
      w_tx_idx_n   = r_tx_idx;
      w_tx_sh_n    = r_tx_sh;
      w_byte_n     = r_byte_tx;
      w_tx_take    = 1'b0;
      w_unrun      = 1'b0;
      if (bus_idle) begin
         w_tx_state_n = TX_IDLE;
         w_tx_idx_n   = '0;
      end else if (w_ev[1] || (w_ev[2] && r_tx_state == TX_ACTIVE
                               && r_tx_idx == NB)) begin
         // Start, or reload once the current word is exhausted.
         if (r_tx_full) begin
            w_tx_sh_n    = r_tx_hold << IW;
            w_byte_n     = r_tx_hold[DW-1 -: IW];
            w_tx_idx_n   = CW'(1);
            w_tx_take    = 1'b1;
            w_tx_state_n = TX_ACTIVE;
         end else begin
            w_byte_n     = TX_IDLE_BYTE;
            w_unrun      = 1'b1;
            w_tx_idx_n   = '0;
            w_tx_state_n = TX_IDLE;
         end
      end else if (w_ev[2] && r_tx_state == TX_ACTIVE) begin
         w_tx_sh_n  = r_tx_sh << IW;
         w_byte_n   = r_tx_sh[DW-1 -: IW];
         w_tx_idx_n = r_tx_idx + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_state <= TX_IDLE;
         r_tx_idx   <= '0;
         r_tx_sh    <= '0;
         r_byte_tx  <= TX_IDLE_BYTE;
      end else begin
         r_tx_state <= w_tx_state_n;
         r_tx_idx   <= w_tx_idx_n;
         r_tx_sh    <= w_tx_sh_n;
         r_byte_tx  <= w_byte_n;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_full <= 1'b0;
         r_tx_hold <= '0;
      end else if (w_tx_take) begin
         r_tx_full <= 1'b0;
      end else if (tx_valid && !r_tx_full) begin
         r_tx_full <= 1'b1;
         r_tx_hold <= tx_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_overflow <= 1'b0;
         tx_underrun <= 1'b0;
      end else begin
         if (err_clr)
            rx_overflow <= 1'b0;
         else if (w_rx_done && w_fifo_full && !w_pop)
            rx_overflow <= 1'b1;
         if (err_clr)
            tx_underrun <= 1'b0;
         else if (w_unrun)
            tx_underrun <= 1'b1;
      end
   end

endmodule
